// File: rtl/seven_seg_scan.sv
// seven_seg_scan: four-digit multiplexed seven-segment driver with frame-aligned value updates.
module seven_seg_scan #(
  parameter int CLK_DIVIDE     = 100000,
  parameter bit ACTIVE_LOW_SEG = 1'b1,
  parameter bit ACTIVE_LOW_AN  = 1'b1,
  parameter bit BLANK_LEADING  = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] packed_bcd_in,
  input  logic        packed_bcd_in_valid,
  input  logic [3:0]  dp_in,
  input  logic        enable,
  output logic [6:0]  seg_out,
  output logic        dp_out,
  output logic [3:0]  an_out
);
  localparam int CW = $clog2(CLK_DIVIDE);
  localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIVIDE - 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [15:0]   disp_val_q, disp_val_d, pend_val_q, pend_val_d;
  logic [3:0]    disp_dp_q, disp_dp_d, pend_dp_q, pend_dp_d;
  logic          pend_q, pend_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;
  logic [3:0]    an_q, an_d;
  logic          tick, boundary, blank;
  logic [3:0]    nib;
  logic [6:0]    dec;
  assign tick     = cnt_q == CNT_MAX;
  assign boundary = tick && idx_q == 2'd3;
  assign nib      = disp_val_q[{idx_q, 2'b00} +: 4];
  always_comb begin
    case (nib)
      4'd0:    dec = 7'h3F;
      4'd1:    dec = 7'h06;
      4'd2:    dec = 7'h5B;
      4'd3:    dec = 7'h4F;
      4'd4:    dec = 7'h66;
      4'd5:    dec = 7'h6D;
      4'd6:    dec = 7'h7D;
      4'd7:    dec = 7'h07;
      4'd8:    dec = 7'h7F;
      4'd9:    dec = 7'h6F;
      default: dec = 7'h40;
    endcase
  end
  // A digit is a leading zero only if it and every more significant nibble are zero.
  assign blank = BLANK_LEADING && (idx_q == 2'd3 ? disp_val_q[15:12] == 4'd0 :
                                   idx_q == 2'd2 ? disp_val_q[15:8]  == 8'd0 :
                                   idx_q == 2'd1 ? disp_val_q[15:4]  == 12'd0 : 1'b0);
  always_comb begin
    cnt_d      = tick ? '0 : cnt_q + CW'(1);
    idx_d      = tick ? idx_q + 2'd1 : idx_q;
    disp_val_d = disp_val_q;
    disp_dp_d  = disp_dp_q;
    pend_val_d = packed_bcd_in_valid ? packed_bcd_in : pend_val_q;
    pend_dp_d  = packed_bcd_in_valid ? dp_in : pend_dp_q;
    pend_d     = pend_q | packed_bcd_in_valid;
    if (boundary) begin
      disp_val_d = packed_bcd_in_valid ? packed_bcd_in : pend_q ? pend_val_q : disp_val_q;
      disp_dp_d  = packed_bcd_in_valid ? dp_in : pend_q ? pend_dp_q : disp_dp_q;
      pend_d     = 1'b0;
    end
    seg_d = (blank ? 7'h00 : dec) ^ {7{ACTIVE_LOW_SEG}};
    dp_d  = disp_dp_q[idx_q] ^ ACTIVE_LOW_SEG;
    an_d  = (enable ? 4'b0001 << idx_q : 4'b0000) ^ {4{ACTIVE_LOW_AN}};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      idx_q      <= 2'd0;
      disp_val_q <= 16'h0000;
      disp_dp_q  <= 4'h0;
      pend_val_q <= 16'h0000;
      pend_dp_q  <= 4'h0;
      pend_q     <= 1'b0;
      seg_q      <= {7{ACTIVE_LOW_SEG}};
      dp_q       <= ACTIVE_LOW_SEG;
      an_q       <= {4{ACTIVE_LOW_AN}};
    end else begin
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      disp_val_q <= disp_val_d;
      disp_dp_q  <= disp_dp_d;
      pend_val_q <= pend_val_d;
      pend_dp_q  <= pend_dp_d;
      pend_q     <= pend_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
      an_q       <= an_d;
    end
  end
  assign seg_out = seg_q;
  assign dp_out  = dp_q;
  assign an_out  = an_q;
endmodule

// File: tb/tb_seven_seg_scan.sv
// tb_seven_seg_scan: cycle-level scoreboard for two polarity/blanking builds of seven_seg_scan.
module tb_seven_seg_scan;
  localparam int CD = 4;
  localparam int FR = 4 * CD;
  logic        clk = 1'b0, rst = 1'b1, vld = 1'b0, en = 1'b1;
  logic [15:0] bcd = 16'h0000;
  logic [3:0]  dpi = 4'h0;
  logic [6:0]  seg_a, seg_b;
  logic        dp_a, dp_b;
  logic [3:0]  an_a, an_b;
  int          n_cmp = 0, n_err = 0;
  logic [23:0] exp_q[$];
  int          k = 0;
  logic [15:0] m_val = 16'h0, m_pval = 16'h0;
  logic [3:0]  m_dp = 4'h0, m_pdp = 4'h0;
  bit          m_flag = 1'b0;
  string       phase = "reset";
  logic [6:0]  seg_tbl [0:9] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  seven_seg_scan #(.CLK_DIVIDE(CD), .ACTIVE_LOW_SEG(1'b0), .ACTIVE_LOW_AN(1'b0), .BLANK_LEADING(1'b1)) u_dut_a (
    .clk(clk), .rst(rst), .packed_bcd_in(bcd), .packed_bcd_in_valid(vld), .dp_in(dpi),
    .enable(en), .seg_out(seg_a), .dp_out(dp_a), .an_out(an_a));
  seven_seg_scan #(.CLK_DIVIDE(CD), .ACTIVE_LOW_SEG(1'b1), .ACTIVE_LOW_AN(1'b1), .BLANK_LEADING(1'b0)) u_dut_b (
    .clk(clk), .rst(rst), .packed_bcd_in(bcd), .packed_bcd_in_valid(vld), .dp_in(dpi),
    .enable(en), .seg_out(seg_b), .dp_out(dp_b), .an_out(an_b));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [11:0] got, input logic [11:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got an/dp/seg=%h expected=%h", tag, got, exp);
    end
  endtask

  // Expected {an,dp,seg} for the digit at position idx, from the model's displayed value.
  function automatic logic [11:0] expect_out(input bit al_seg, input bit al_an, input bit bl,
                                             input int idx, input bit e);
    int         h;
    logic [3:0] n;
    logic [6:0] s;
    logic       d;
    logic [3:0] a;
    h = -1;
    for (int i = 0; i < 4; i++) if (m_val[i*4 +: 4] != 4'd0) h = i;
    n = m_val[idx*4 +: 4];
    s = (bl && idx > 0 && idx > h) ? 7'h00 : (n > 4'd9 ? 7'h40 : seg_tbl[n]);
    d = m_dp[idx];
    a = e ? 4'(1 << idx) : 4'h0;
    if (al_seg) begin
      s = ~s;
      d = ~d;
    end
    if (al_an) a = ~a;
    return {a, d, s};
  endfunction

  task automatic cyc(input bit r, input bit v, input logic [15:0] b, input logic [3:0] d, input bit e);
    logic [11:0] ea, eb;
    int          idx;
    rst = r; vld = v; bcd = b; dpi = d; en = e;
    @(posedge clk);
    if (r) begin
      k = 0; m_val = 16'h0; m_dp = 4'h0; m_flag = 1'b0;
      ea = 12'h000;
      eb = 12'hFFF;
    end else begin
      idx = (k / CD) % 4;
      ea = expect_out(1'b0, 1'b0, 1'b1, idx, e);
      eb = expect_out(1'b1, 1'b1, 1'b0, idx, e);
      if (k % FR == FR - 1) begin
        if (v) begin
          m_val = b; m_dp = d;
        end else if (m_flag) begin
          m_val = m_pval; m_dp = m_pdp;
        end
        m_flag = 1'b0;
      end else if (v) begin
        m_pval = b; m_pdp = d; m_flag = 1'b1;
      end
      k++;
    end
    exp_q.push_back({ea, eb});
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 1'b0, 16'h0, 4'h0, 1'b1);
  endtask

  task automatic to_phase(input int p);
    while (k % FR != p) idle(1);
  endtask

  task automatic send(input logic [15:0] b, input logic [3:0] d);
    cyc(1'b0, 1'b1, b, d, 1'b1);
  endtask

  always @(negedge clk) begin
    logic [23:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check({phase, "/a"}, {an_a, dp_a, seg_a}, e[23:12]);
      check({phase, "/b"}, {an_b, dp_b, seg_b}, e[11:0]);
    end
  end

  initial begin
    repeat (3) cyc(1'b1, 1'b0, 16'h0, 4'h0, 1'b1);
    phase = "idle";
    idle(3 * FR);
    phase = "basic";
    to_phase(6);
    send(16'h1234, 4'b0100);
    idle(3 * FR);
    phase = "blank";
    send(16'h0050, 4'b0010);
    idle(3 * FR);
    phase = "tear";
    to_phase(5);
    send(16'h1111, 4'b0001);
    idle(3);
    send(16'h2222, 4'b0000);
    idle(2 * FR);
    to_phase(FR - 1);
    send(16'h9999, 4'b1111);
    idle(2 * FR);
    phase = "invalid";
    send(16'h0A0F, 4'b1001);
    idle(3 * FR);
    phase = "enable";
    to_phase(3);
    repeat (10) cyc(1'b0, 1'b0, 16'h0, 4'h0, 1'b0);
    idle(2 * FR);
    phase = "rst_mid";
    to_phase(3);
    send(16'h4321, 4'b1111);
    idle(2);
    cyc(1'b1, 1'b1, 16'h7777, 4'b1111, 1'b1);
    cyc(1'b1, 1'b0, 16'h0, 4'h0, 1'b1);
    idle(3 * FR);
    phase = "random";
    repeat (400)
      cyc(1'b0, $urandom_range(0, 9) == 0, 16'($urandom), 4'($urandom), $urandom_range(0, 7) != 0);
    @(negedge clk);
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
